// File: rtl/lif_neuron_array.sv
// lif_neuron_array: a parametrised array of leaky integrate-and-fire neurons.
// Each channel integrates its own unsigned input current, leaks by a shared
// programmable right shift, and fires a one-cycle spike when the saturated
// membrane potential reaches the shared threshold. After firing, the channel
// clears and sits out REFRAC refractory cycles.
//
// Optional feature macro: LIF_LATERAL_INHIB_EN
//   When defined, any enabled cycle with at least one crossing halves the
//   stored potential of every other non-refractory, non-crossing channel.
//   When undefined, no cross-channel logic exists.
module lif_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8,
    parameter int REFRAC    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [N_NEURONS*WIDTH-1:0]   cur_in,
    input  logic [WIDTH-1:0]             threshold,
    input  logic [$clog2(WIDTH)-1:0]     leak_shift,
    output logic [N_NEURONS*WIDTH-1:0]   state,
    output logic [N_NEURONS-1:0]         spike,
    output logic                         spike_any
);

    localparam int SHW = $clog2(WIDTH);
    // Refractory counter is at least one bit wide so REFRAC=0 still builds.
    localparam int RCW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [RCW-1:0] RC_LOAD = RCW'(REFRAC);
    // WIDTH widened by one bit so a shift amount of WIDTH or more is detectable.
    localparam logic [SHW:0] WIDTH_L = (SHW + 1)'(WIDTH);

    // Registered per-channel state
    logic [WIDTH-1:0]     state_q [N_NEURONS];
    logic [WIDTH-1:0]     state_d [N_NEURONS];
    logic [RCW-1:0]       rc_q    [N_NEURONS];
    logic [RCW-1:0]       rc_d    [N_NEURONS];
    logic [N_NEURONS-1:0] spike_q;
    logic [N_NEURONS-1:0] spike_d;
    logic                 spike_any_q;
    logic                 spike_any_d;

    // Per-channel datapath intermediates
    logic [WIDTH-1:0]     leak_w  [N_NEURONS];
    logic [WIDTH:0]       sum_w   [N_NEURONS];
    logic [WIDTH-1:0]     sat_w   [N_NEURONS];
    logic [N_NEURONS-1:0] fire_w;

`ifdef LIF_LATERAL_INHIB_EN
    logic                 fire_any_w;
`endif

    // Leak, integrate and saturate each channel; flag threshold crossings.
    always_comb begin
        for (int i = 0; i < N_NEURONS; i++) begin
            // A shift of WIDTH or more would drain nothing, so it means no leak.
            if ({1'b0, leak_shift} >= WIDTH_L) begin
                leak_w[i] = '0;
            end else begin
                leak_w[i] = state_q[i] >> leak_shift;
            end
            // state - leak can never go negative, so only overflow needs care.
            sum_w[i]  = {1'b0, state_q[i]} - {1'b0, leak_w[i]}
                      + {1'b0, cur_in[i*WIDTH +: WIDTH]};
            sat_w[i]  = sum_w[i][WIDTH] ? '1 : sum_w[i][WIDTH-1:0];
            fire_w[i] = (rc_q[i] == '0) && (sat_w[i] >= threshold);
        end
    end

`ifdef LIF_LATERAL_INHIB_EN
    // Any enabled crossing in the array inhibits the remaining channels.
    always_comb begin
        fire_any_w = ena && (|fire_w);
    end
`endif

    // Next-state selection: hold, refractory countdown, fire, or integrate.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        spike_d = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            state_d[i] = state_q[i];
            rc_d[i]    = rc_q[i];
        end

        if (ena) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (rc_q[i] != '0) begin
                    // Refractory: input is ignored and the potential stays cleared.
                    state_d[i] = '0;
                    rc_d[i]    = rc_q[i] - RCW'(1);
                end else if (fire_w[i]) begin
                    spike_d[i] = 1'b1;
                    state_d[i] = '0;
                    rc_d[i]    = RC_LOAD;
                end else begin
`ifdef LIF_LATERAL_INHIB_EN
                    state_d[i] = fire_any_w ? (sat_w[i] >> 1) : sat_w[i];
`else
                    state_d[i] = sat_w[i];
`endif
                end
            end
        end

        spike_any_d = |spike_d;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-channel arrays are ordinary flops, not a RAM, so
            // they are cleared here like any other register.
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= '0;
                rc_q[i]    <= '0;
            end
            spike_q     <= '0;
            spike_any_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others.
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= state_d[i];
                rc_q[i]    <= rc_d[i];
            end
            spike_q     <= spike_d;
            spike_any_q <= spike_any_d;
        end
    end

    // Pack per-channel registers onto the flat output bus.
    always_comb begin
        for (int i = 0; i < N_NEURONS; i++) begin
            state[i*WIDTH +: WIDTH] = state_q[i];
        end
    end

    assign spike     = spike_q;
    assign spike_any = spike_any_q;

endmodule
